// File: rtl/id_pkg.sv
// id_pkg: 1RI20 opcodes, ALU codes, decoded-lane record and skid-buffer states.
package id_pkg;
    localparam logic [6:0] OP_LU12I     = 7'b0001010;
    localparam logic [6:0] OP_PCADDI    = 7'b0001100;
    localparam logic [6:0] OP_PCALAU12I = 7'b0001101;
    localparam logic [6:0] OP_PCADDU12I = 7'b0001110;

    localparam logic [7:0] ALU_NOP       = 8'h00;
    localparam logic [7:0] ALU_LU12I     = 8'h61;
    localparam logic [7:0] ALU_PCADDU12I = 8'h62;
    localparam logic [7:0] ALU_PCADDI    = 8'h63;
    localparam logic [7:0] ALU_PCALAU12I = 8'h64;

    localparam logic [2:0] ALU_SEL_NOP        = 3'b000;
    localparam logic [2:0] ALU_SEL_ARITHMETIC = 3'b100;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        inst_valid;
        logic        ine;
        logic        reg_we;
        logic [4:0]  rd;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] imm;
        logic [31:0] result;
    } dec_1ri20_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;
endpackage

// File: rtl/id_1ri20_lane_dec.sv
// id_1ri20_lane_dec: combinational decode and writeback value for one 1RI20 lane.
module id_1ri20_lane_dec
    import id_pkg::*;
#(
    parameter int EN_PCADDI    = 1,
    parameter int EN_PCALAU12I = 1
) (
    input  logic        valid,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output dec_1ri20_t  d
);
    logic [19:0] si20;
    logic [6:0]  op;
    logic        is_lu, is_pu, is_pi, is_pa, hit;
    logic [31:0] imm_hi, imm_pi;

    assign si20   = inst[24:5];
    assign op     = inst[31:25];
    assign is_lu  = op == OP_LU12I;
    assign is_pu  = op == OP_PCADDU12I;
    assign is_pi  = (EN_PCADDI != 0) && op == OP_PCADDI;
    assign is_pa  = (EN_PCALAU12I != 0) && op == OP_PCALAU12I;
    assign hit    = valid && (is_lu || is_pu || is_pi || is_pa);
    assign imm_hi = {si20, 12'b0};
    assign imm_pi = {{10{si20[19]}}, si20, 2'b0};

    always_comb begin
        d            = '0;
        d.pc         = pc;
        d.inst       = inst;
        d.inst_valid = hit;
        d.ine        = valid && !hit;
        d.rd         = valid ? inst[4:0] : 5'd0;
        d.reg_we     = hit && |inst[4:0];
        d.alusel     = hit ? ALU_SEL_ARITHMETIC : ALU_SEL_NOP;
        d.aluop      = !hit ? ALU_NOP : is_lu ? ALU_LU12I : is_pu ? ALU_PCADDU12I :
                       is_pi ? ALU_PCADDI : ALU_PCALAU12I;
        d.imm        = !hit ? 32'd0 : is_pi ? imm_pi : imm_hi;
        d.result     = !hit ? 32'd0 : is_lu ? imm_hi :
                       is_pa ? {pc[31:12], 12'b0} + imm_hi : pc + d.imm;
    end
endmodule

// File: rtl/id_1ri20_multi_dec.sv
// id_1ri20_multi_dec: LANES-wide 1RI20 decoder registered behind a 2-entry skid buffer.
module id_1ri20_multi_dec
    import id_pkg::*;
#(
    parameter int LANES        = 2,
    parameter int EN_PCADDI    = 1,
    parameter int EN_PCALAU12I = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [LANES-1:0]      in_valid,
    input  logic [LANES*32-1:0]   in_pc,
    input  logic [LANES*32-1:0]   in_inst,
    output logic                  in_ready,
    output logic [LANES-1:0]      out_valid,
    input  logic                  out_ready,
    output logic [LANES*32-1:0]   out_pc,
    output logic [LANES*32-1:0]   out_inst,
    output logic [LANES-1:0]      out_inst_valid,
    output logic [LANES-1:0]      out_ine,
    output logic [LANES-1:0]      out_reg_we,
    output logic [LANES*5-1:0]    out_rd,
    output logic [LANES*8-1:0]    out_aluop,
    output logic [LANES*3-1:0]    out_alusel,
    output logic [LANES*32-1:0]   out_imm,
    output logic [LANES*32-1:0]   out_result
);
    dec_1ri20_t [LANES-1:0] dec, main_q, skid_q;
    logic [LANES-1:0]       main_v, skid_v;
    buf_state_t             state, nxt;
    logic                   acc, con, ld_main, ld_skid, mv_skid;

    genvar i;
    for (i = 0; i < LANES; i++) begin : g_lane
        id_1ri20_lane_dec #(.EN_PCADDI(EN_PCADDI), .EN_PCALAU12I(EN_PCALAU12I)) u_dec (
            .valid(in_valid[i]),
            .pc   (in_pc[i*32+:32]),
            .inst (in_inst[i*32+:32]),
            .d    (dec[i])
        );
        assign out_pc[i*32+:32]     = main_q[i].pc;
        assign out_inst[i*32+:32]   = main_q[i].inst;
        assign out_inst_valid[i]    = main_q[i].inst_valid;
        assign out_ine[i]           = main_q[i].ine;
        assign out_reg_we[i]        = main_q[i].reg_we;
        assign out_rd[i*5+:5]       = main_q[i].rd;
        assign out_aluop[i*8+:8]    = main_q[i].aluop;
        assign out_alusel[i*3+:3]   = main_q[i].alusel;
        assign out_imm[i*32+:32]    = main_q[i].imm;
        assign out_result[i*32+:32] = main_q[i].result;
    end

    assign in_ready  = state != TWO;
    assign out_valid = main_v;
    assign acc       = |in_valid && in_ready && !flush;
    assign con       = |out_valid && out_ready;

    always_comb begin
        nxt     = state;
        ld_main = 1'b0;
        ld_skid = 1'b0;
        mv_skid = 1'b0;
        case (state)
            EMPTY: if (acc) begin
                nxt     = ONE;
                ld_main = 1'b1;
            end
            ONE: if (acc && con) ld_main = 1'b1;
                 else if (acc) begin
                     nxt     = TWO;
                     ld_skid = 1'b1;
                 end
                 else if (con) nxt = EMPTY;
            TWO: if (con) begin
                nxt     = ONE;
                mv_skid = 1'b1;
            end
            default: nxt = EMPTY;
        endcase
        if (flush) nxt = EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= '0;
            main_v <= '0;
            skid_q <= '0;
            skid_v <= '0;
        end else begin
            state <= nxt;
            if (ld_main) begin
                main_q <= dec;
                main_v <= in_valid;
            end
            if (mv_skid) begin
                main_q <= skid_q;
                main_v <= skid_v;
            end
            if (ld_skid) begin
                skid_q <= dec;
                skid_v <= in_valid;
            end
            // Emptied by consume or flush: drop lane valids, keep data for stability.
            if (nxt == EMPTY) main_v <= '0;
        end
    end
endmodule

// File: tb/tb_id_1ri20_multi_dec.sv
// tb_id_1ri20_multi_dec: directed vectors for decode, backpressure, flush and async reset.
module tb_id_1ri20_multi_dec;
    import id_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, out_ready;
    logic [1:0]  in_valid;
    logic [63:0] in_pc, in_inst;
    logic        in_ready;
    logic [1:0]  out_valid, out_inst_valid, out_ine, out_reg_we;
    logic [63:0] out_pc, out_inst, out_imm, out_result;
    logic [9:0]  out_rd;
    logic [15:0] out_aluop;
    logic [5:0]  out_alusel;

    logic        d_in_ready, d_out_valid, d_inst_valid, d_ine, d_reg_we;
    logic [31:0] d_pc, d_inst, d_imm, d_result;
    logic [4:0]  d_rd;
    logic [7:0]  d_aluop;
    logic [2:0]  d_alusel;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_1ri20_multi_dec #(.LANES(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_inst_valid(out_inst_valid),
        .out_ine(out_ine), .out_reg_we(out_reg_we), .out_rd(out_rd),
        .out_aluop(out_aluop), .out_alusel(out_alusel), .out_imm(out_imm),
        .out_result(out_result)
    );

    id_1ri20_multi_dec #(.LANES(1), .EN_PCADDI(0), .EN_PCALAU12I(0)) dut_dis (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid[0]), .in_pc(in_pc[31:0]), .in_inst(in_inst[31:0]),
        .in_ready(d_in_ready),
        .out_valid(d_out_valid), .out_ready(1'b1),
        .out_pc(d_pc), .out_inst(d_inst), .out_inst_valid(d_inst_valid),
        .out_ine(d_ine), .out_reg_we(d_reg_we), .out_rd(d_rd),
        .out_aluop(d_aluop), .out_alusel(d_alusel), .out_imm(d_imm),
        .out_result(d_result)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic lane(input string t, input int l, input logic [31:0] ex_imm,
                        input logic [31:0] ex_res, input logic iv, input logic ine,
                        input logic we, input logic [7:0] op);
        chk({t, ".imm"}, out_imm[l*32+:32], ex_imm);
        chk({t, ".res"}, out_result[l*32+:32], ex_res);
        chk({t, ".iv"}, 32'(out_inst_valid[l]), 32'(iv));
        chk({t, ".ine"}, 32'(out_ine[l]), 32'(ine));
        chk({t, ".we"}, 32'(out_reg_we[l]), 32'(we));
        chk({t, ".op"}, 32'(out_aluop[l*8+:8]), 32'(op));
        chk({t, ".sel"}, 32'(out_alusel[l*3+:3]), 32'(iv ? ALU_SEL_ARITHMETIC : ALU_SEL_NOP));
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [19:0] si, input logic [4:0] rd);
        return {op, si, rd};
    endfunction

    task automatic put(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] i0,
                       input logic [31:0] p1, input logic [31:0] i1);
        in_valid = v;
        in_pc    = {p1, p0};
        in_inst  = {i1, i0};
    endtask

    task automatic grp(input logic [19:0] k);
        put(2'b11, {8'd0, k, 4'd0}, mk(OP_LU12I, k, 5'd1),
            {8'd0, k, 4'd4}, mk(OP_LU12I, k + 20'h100, 5'd2));
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        put(2'b00, 0, 0, 0, 0);
        repeat (2) step();
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.ready", 32'(in_ready), 32'd1);
        chk("rst.res0", out_result[31:0], 32'd0);
        rst_n = 1'b1;

        put(2'b11, 32'h1C000000, mk(OP_LU12I, 20'h12345, 5'd3),
                   32'h1C000010, mk(OP_PCADDI, 20'hFFFFF, 5'd4));
        step();
        chk("lu.valid", 32'(out_valid), 32'd3);
        chk("lu.rd", 32'(out_rd[4:0]), 32'd3);
        chk("lu.pc", out_pc[31:0], 32'h1C000000);
        lane("lu", 0, 32'h12345000, 32'h12345000, 1, 0, 1, ALU_LU12I);
        lane("pcaddi", 1, 32'hFFFFFFFC, 32'h1C00000C, 1, 0, 1, ALU_PCADDI);
        chk("dis.lu.res", d_result, 32'h12345000);
        chk("dis.lu.iv", 32'(d_inst_valid), 32'd1);

        put(2'b11, 32'h1C000ABC, mk(OP_PCALAU12I, 20'h00001, 5'd6),
                   32'h1C000AC0, mk(OP_LU12I, 20'hABCDE, 5'd0));
        step();
        lane("pcala", 0, 32'h00001000, 32'h1C001000, 1, 0, 1, ALU_PCALAU12I);
        lane("lu_rd0", 1, 32'hABCDE000, 32'hABCDE000, 1, 0, 0, ALU_LU12I);
        chk("dis.pcala.ine", 32'(d_ine), 32'd1);
        chk("dis.pcala.iv", 32'(d_inst_valid), 32'd0);
        chk("dis.pcala.we", 32'(d_reg_we), 32'd0);
        chk("dis.pcala.res", d_result, 32'd0);

        put(2'b11, 32'h1C000020, mk(OP_PCADDI, 20'h00001, 5'd5),
                   32'h1C000024, mk(7'h7F, 20'h12345, 5'd7));
        step();
        lane("pcaddi+", 0, 32'h00000004, 32'h1C000024, 1, 0, 1, ALU_PCADDI);
        lane("op7f", 1, 32'd0, 32'd0, 0, 1, 0, ALU_NOP);
        chk("dis.pcaddi.ine", 32'(d_ine), 32'd1);
        chk("dis.pcaddi.iv", 32'(d_inst_valid), 32'd0);
        chk("dis.pcaddi.we", 32'(d_reg_we), 32'd0);

        put(2'b01, 32'h1C000000, mk(OP_PCADDU12I, 20'h80000, 5'd1),
                   32'h1C000004, mk(OP_LU12I, 20'h00042, 5'd9));
        step();
        chk("pos.valid", 32'(out_valid), 32'd1);
        lane("pcaddu", 0, 32'h80000000, 32'h9C000000, 1, 0, 1, ALU_PCADDU12I);
        lane("novalid", 1, 32'd0, 32'd0, 0, 0, 0, ALU_NOP);

        put(2'b00, 0, 0, 0, 0);
        step();
        chk("idle.valid", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        grp(20'd1);
        step();
        chk("bp1.ready", 32'(in_ready), 32'd1);
        chk("bp1.res0", out_result[31:0], 32'h00001000);
        grp(20'd2);
        step();
        chk("bp2.ready", 32'(in_ready), 32'd0);
        chk("bp2.res0", out_result[31:0], 32'h00001000);
        grp(20'd3);
        step();
        chk("bp3.ready", 32'(in_ready), 32'd0);
        chk("bp3.res0", out_result[31:0], 32'h00001000);
        chk("bp3.res1", out_result[63:32], 32'h00101000);
        put(2'b00, 0, 0, 0, 0);
        out_ready = 1'b1;
        step();
        chk("bp4.valid", 32'(out_valid), 32'd3);
        chk("bp4.res0", out_result[31:0], 32'h00002000);
        chk("bp4.res1", out_result[63:32], 32'h00102000);
        step();
        chk("bp5.valid", 32'(out_valid), 32'd0);
        chk("bp5.ready", 32'(in_ready), 32'd1);

        out_ready = 1'b0;
        grp(20'd4);
        step();
        grp(20'd5);
        step();
        chk("fl.ready0", 32'(in_ready), 32'd0);
        grp(20'd6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl.valid", 32'(out_valid), 32'd0);
        chk("fl.ready", 32'(in_ready), 32'd1);
        put(2'b00, 0, 0, 0, 0);
        out_ready = 1'b1;
        step();
        chk("fl.drop", 32'(out_valid), 32'd0);
        grp(20'd7);
        step();
        chk("fl.next.valid", 32'(out_valid), 32'd3);
        chk("fl.next.res0", out_result[31:0], 32'h00007000);

        put(2'b00, 0, 0, 0, 0);
        step();
        out_ready = 1'b0;
        grp(20'd8);
        step();
        chk("ar.pre", out_result[31:0], 32'h00008000);
        put(2'b00, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar.valid", 32'(out_valid), 32'd0);
        chk("ar.res0", out_result[31:0], 32'd0);
        chk("ar.pc0", out_pc[31:0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        grp(20'd9);
        out_ready = 1'b1;
        step();
        chk("ar.post.valid", 32'(out_valid), 32'd3);
        chk("ar.post.res0", out_result[31:0], 32'h00009000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
